// File: rtl/rv_ifetch_if.sv
// rv_ifetch_if: instruction-memory read port plus decode handshake of the fetch unit.
interface rv_ifetch_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   modport master (output imem_addr, inst_valid, inst_data, inst_pc, input imem_rdata, inst_ready);
   modport slave (input imem_addr, inst_valid, inst_data, inst_pc, output imem_rdata, inst_ready);
endinterface

// File: rtl/rv_ifetch.sv
// rv_ifetch: fetch unit with a small {pc, instr} queue, redirect and halt on EBREAK.
// Defining IFETCH_PERF_EN adds saturating stall/fetch performance counters.
module rv_ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   rv_ifetch_if.master bus,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
`ifdef IFETCH_PERF_EN
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_fetch_cnt,
`endif
   output logic        halted
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(QDEPTH);
   localparam logic [31:0] EBREAK = 32'h00100073;
   typedef enum logic [1:0] {RUN, STOP, HALT} state_t;
   state_t state, state_n;
   logic [31:0] fetch_pc;
   logic [31:0] q_pc [QDEPTH];
   logic [31:0] q_data [QDEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic push, pop;
   assign bus.imem_addr  = fetch_pc;
   assign bus.inst_valid = count != '0;
   assign bus.inst_pc    = q_pc[rptr];
   assign bus.inst_data  = q_data[rptr];
   assign halted = state == HALT;
   assign pop  = bus.inst_valid && bus.inst_ready;
   assign push = state == RUN && !redirect_valid && (count < FULL || pop);
   // In STOP the EBREAK is the only remaining entry once count reaches 1.
   always_comb begin
      state_n = redirect_valid ? RUN :
                (state == RUN && push && bus.imem_rdata == EBREAK) ? STOP :
                (state == STOP && pop && count == CW'(1)) ? HALT : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
         count    <= '0;
         wptr     <= '0;
         rptr     <= '0;
      end else begin
         state <= state_n;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~32'h3;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + 32'd4;
               wptr     <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wptr]   <= fetch_pc;
         q_data[wptr] <= bus.imem_rdata;
      end
   end
`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_fetch_cnt <= '0;
      end else begin
         if (bus.inst_valid && !bus.inst_ready && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (push && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
   end
`endif
endmodule
